// File: rtl/stack_engine.sv
// Stacker game logic: bounces the sliding block, trims it on drop, tracks level/win/game over.
// Latency: outputs registered, button effect 3 clks after rise (drop to level: 4); no backpressure, ticks never queued.
module stack_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BLOCK_H    = 20,
  parameter int INIT_W     = 160,
  parameter int STEP       = 4,
  parameter int MAX_LEVELS = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       drop,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [9:0] width,
  output logic [9:0] base_x,
  output logic [9:0] base_w,
  output logic [9:0] height,
  output logic [4:0] level,
  output logic       game_over,
  output logic       win
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MOVE   = 3'd1;
  localparam logic [2:0] S_PAUSED = 3'd2;
  localparam logic [2:0] S_PLACE  = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [9:0]  X0   = 10'((SCREEN_W - INIT_W) / 2);
  localparam logic [9:0]  Y0   = 10'(SCREEN_H - 2 * BLOCK_H);
  localparam logic [9:0]  W0   = 10'(INIT_W);
  localparam logic [9:0]  BH   = 10'(BLOCK_H);
  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] ST   = 11'(STEP);
  localparam logic [4:0]  LMAX = 5'(MAX_LEVELS);

  logic [2:0] state;
  logic       dir_left;

  // bit order {start, pause, drop}
  logic [2:0] btn_s1, btn_s2, btn_prev, btn_edge;
  logic       start_e, pause_e, drop_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1   <= 3'b000;
      btn_s2   <= 3'b000;
      btn_prev <= 3'b000;
    end else begin
      btn_s1   <= {start, pause, drop};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_edge = btn_s2 & ~btn_prev;
  assign start_e  = btn_edge[2];
  assign pause_e  = btn_edge[1];
  assign drop_e   = btn_edge[0];

  // 11-bit geometry so right edges (up to SCREEN_W + STEP) never wrap
  logic [10:0] px, w, bx, bw, lo, hi;
  logic [9:0]  ov_w;
  logic        overlap, hit_right, hit_left;

  always_comb begin
    px        = {1'b0, pos_x};
    w         = {1'b0, width};
    bx        = {1'b0, base_x};
    bw        = {1'b0, base_w};
    lo        = (px > bx) ? px : bx;
    hi        = ((px + w) < (bx + bw)) ? (px + w) : (bx + bw);
    overlap   = hi > lo;
    ov_w      = 10'(hi - lo);
    hit_right = (px + w + ST) >= SW;
    hit_left  = px < ST;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dir_left  <= 1'b0;
      pos_x     <= 10'd0;
      pos_y     <= Y0;
      width     <= W0;
      base_x    <= X0;
      base_w    <= W0;
      height    <= 10'd0;
      level     <= 5'd0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else if (start_e) begin
      // start outranks everything and restarts from any state, including IDLE
      state     <= S_MOVE;
      dir_left  <= 1'b0;
      pos_x     <= 10'd0;
      pos_y     <= Y0;
      width     <= W0;
      base_x    <= X0;
      base_w    <= W0;
      height    <= 10'd0;
      level     <= 5'd0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      case (state)
        S_MOVE: begin
          if (pause_e) begin
            state <= S_PAUSED;
          end else if (drop_e) begin
            state <= S_PLACE;
          end else if (tick) begin
            if (!dir_left) begin
              if (hit_right) begin
                pos_x    <= 10'(SW - w);
                dir_left <= 1'b1;
              end else begin
                pos_x <= 10'(px + ST);
              end
            end else if (hit_left) begin
              pos_x    <= 10'd0;
              dir_left <= 1'b0;
            end else begin
              pos_x <= 10'(px - ST);
            end
          end
        end
        S_PAUSED: begin
          if (pause_e) state <= S_MOVE;
        end
        S_PLACE: begin
          if (!overlap) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            win       <= 1'b0;
          end else begin
            base_x   <= lo[9:0];
            base_w   <= ov_w;
            width    <= ov_w;
            level    <= level + 5'd1;
            height   <= height + BH;
            pos_y    <= pos_y - BH;
            pos_x    <= 10'd0;
            dir_left <= 1'b0;
            if (level + 5'd1 == LMAX) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              win       <= 1'b1;
            end else begin
              state <= S_MOVE;
            end
          end
        end
        S_IDLE, S_OVER: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
